// File: rtl/gcd_controller.sv
// Control FSM for a 16-bit subtractive GCD datapath: loads A then B from data_in, then
// issues one subtract per cycle until A==B, with zero-operand, bad-flag and timeout errors.
module gcd_controller #(
  parameter int          WIDTH    = 16,
  parameter int          CNT_W    = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic             LdA,
  output logic             LdB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ITER - 1);

  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_issue;

  // RUN controls follow the live compare flags, which change after every subtract,
  // so they are decoded combinationally from the state register and the flags.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    zero_d    = zero_q;
    cnt_d     = cnt_q;
    sub_issue = 1'b0;
    LdA       = 1'b0;
    LdB       = 1'b0;
    sel1      = 1'b0;
    sel2      = 1'b0;
    sel_in    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          err_d   = 1'b0;
          zero_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_LOAD_A: begin
        LdA     = 1'b1;
        sel_in  = 1'b1;
        busy    = 1'b1;
        if (data_in == '0) zero_d = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        LdB    = 1'b1;
        sel_in = 1'b1;
        busy   = 1'b1;
        if (zero_q || (data_in == '0)) begin
          zero_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        case ({gt, eq, lt})
          3'b100: begin
            LdA       = 1'b1;
            sel2      = 1'b1;
            sub_issue = 1'b1;
          end
          3'b001: begin
            LdB       = 1'b1;
            sel1      = 1'b1;
            sub_issue = 1'b1;
          end
          3'b010: begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
        if (sub_issue) begin
          cnt_d = cnt_q + 1'b1;
          // The last permitted subtract still happens; the run then ends in error.
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err        = err_q;
  assign iter_count = cnt_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: two instances (default limit and MAX_ITER=4) each driving a
// behavioural PIPO/MUX/SUB/COMPARE datapath, checked against hand-computed vectors.
module tb_gcd_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = 16'd0;

  logic        gt, eq, lt, LdA, LdB, sel1, sel2, sel_in, busy, done, err;
  logic [15:0] iter_count;
  logic [15:0] a_q = 16'd0, b_q = 16'd0;
  logic [15:0] sub_v, mux_v;

  logic        t_gt, t_eq, t_lt, t_LdA, t_LdB, t_sel1, t_sel2, t_sel_in, t_busy, t_done, t_err;
  logic [15:0] t_iter;
  logic [15:0] ta_q = 16'd0, tb_q = 16'd0;
  logic [15:0] t_sub_v, t_mux_v;

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;
  int sel_viol = 0;
  int lat_m, lat_t;

  always #5 clk = ~clk;

  gcd_controller #(.WIDTH(16), .CNT_W(16), .MAX_ITER(65535)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .gt(gt), .eq(eq), .lt(lt),
    .LdA(LdA), .LdB(LdB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  gcd_controller #(.WIDTH(16), .CNT_W(16), .MAX_ITER(4)) dut_t (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .gt(t_gt), .eq(t_eq), .lt(t_lt),
    .LdA(t_LdA), .LdB(t_LdB), .sel1(t_sel1), .sel2(t_sel2), .sel_in(t_sel_in),
    .busy(t_busy), .done(t_done), .err(t_err), .iter_count(t_iter)
  );

  // Behavioural datapaths
  assign sub_v = (sel1 ? b_q : a_q) - (sel2 ? b_q : a_q);
  assign mux_v = sel_in ? data_in : sub_v;
  assign gt = (a_q > b_q);
  assign eq = (a_q == b_q);
  assign lt = (a_q < b_q);
  always @(posedge clk) begin
    if (LdA) a_q <= mux_v;
    if (LdB) b_q <= mux_v;
  end

  assign t_sub_v = (t_sel1 ? tb_q : ta_q) - (t_sel2 ? tb_q : ta_q);
  assign t_mux_v = t_sel_in ? data_in : t_sub_v;
  assign t_gt = (ta_q > tb_q);
  assign t_eq = (ta_q == tb_q);
  assign t_lt = (ta_q < tb_q);
  always @(posedge clk) begin
    if (t_LdA) ta_q <= t_mux_v;
    if (t_LdB) tb_q <= t_mux_v;
  end

  always @(negedge clk) begin
    if ((LdA && LdB) || (t_LdA && t_LdB)) excl_viol++;
    if ((!LdA && !LdB && (sel1 || sel2)) || (!t_LdA && !t_LdB && (t_sel1 || t_sel2))) sel_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic noise);
    int k;
    k = 0;
    lat_m = 0;
    lat_t = 0;
    @(negedge clk);
    start = 1'b1;
    data_in = 16'h5A5A;
    while (lat_m == 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (t_done && lat_t == 0) lat_t = k;
      if (done) lat_m = k;
      if (k == 1) begin
        check("loadA_ctl", {27'd0, LdA, LdB, sel_in, busy, err}, 32'b10110);
        check("loadA_cnt", {16'd0, iter_count}, 32'd0);
        start = 1'b0;
        data_in = a;
      end else if (k == 2) begin
        check("loadB_ctl", {28'd0, LdA, LdB, sel_in, busy}, 32'b0111);
        data_in = b;
        start = noise;
      end else begin
        data_in = 16'd0;
      end
    end
    if (lat_m == 0) check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_res(input logic [15:0] exp_a, input logic exp_err,
                           input logic [15:0] exp_cnt, input int exp_lat);
    check("latency", lat_m, exp_lat);
    check("result_A", {16'd0, a_q}, {16'd0, exp_a});
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("iter_count", {16'd0, iter_count}, {16'd0, exp_cnt});
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", {30'd0, done, busy}, 32'd0);
    check("err_hold", {31'd0, err}, {31'd0, exp_err});
    check("cnt_hold", {16'd0, iter_count}, {16'd0, exp_cnt});
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_a;
    logic        exp_err;
    logic [15:0] exp_cnt;
    int          exp_lat;
    logic        noise;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'd48, 16'd18, 16'd6,  1'b0, 16'd4,  8,  1'b0};
    vecs[1] = '{16'd7,  16'd7,  16'd7,  1'b0, 16'd0,  4,  1'b1};
    vecs[2] = '{16'd0,  16'd5,  16'd0,  1'b1, 16'd0,  3,  1'b0};
    vecs[3] = '{16'd9,  16'd6,  16'd3,  1'b0, 16'd2,  6,  1'b1};
    vecs[4] = '{16'd5,  16'd0,  16'd5,  1'b1, 16'd0,  3,  1'b0};
    vecs[5] = '{16'd18, 16'd48, 16'd6,  1'b0, 16'd4,  8,  1'b0};
    vecs[6] = '{16'd0,  16'd0,  16'd0,  1'b1, 16'd0,  3,  1'b1};
    vecs[7] = '{16'd13, 16'd1,  16'd1,  1'b0, 16'd12, 16, 1'b0};
    vecs[8] = '{16'd21, 16'd13, 16'd1,  1'b0, 16'd6,  10, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctl", {24'd0, LdA, LdB, sel1, sel2, sel_in, busy, done, err}, 32'd0);
    check("reset_cnt", {16'd0, iter_count}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run(vecs[i].a, vecs[i].b, vecs[i].noise);
      check_res(vecs[i].exp_a, vecs[i].exp_err, vecs[i].exp_cnt, vecs[i].exp_lat);
    end

    // Reset in the middle of a 48/18 run, then a fresh 9/6 run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_in = 16'd48;
    @(negedge clk);
    data_in = 16'd18;
    @(negedge clk);
    data_in = 16'd0;
    @(negedge clk);
    check("midrun_busy", {31'd0, busy}, 32'd1);
    check("midrun_cnt", {16'd0, iter_count}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctl", {24'd0, LdA, LdB, sel1, sel2, sel_in, busy, done, err}, 32'd0);
    check("rst_mid_cnt", {16'd0, iter_count}, 32'd0);
    rst = 1'b0;
    run(16'd9, 16'd6, 1'b0);
    check_res(16'd3, 1'b0, 16'd2, 6);

    // Timeout on the MAX_ITER=4 instance; the default instance runs to completion
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(16'd100, 16'd1, 1'b0);
    check("t_latency", lat_t, 32'd7);
    check("t_result_A", {16'd0, ta_q}, 32'd96);
    check("t_err", {31'd0, t_err}, 32'd1);
    check("t_iter_count", {16'd0, t_iter}, 32'd4);
    check("t_idle", {30'd0, t_busy, t_done}, 32'd0);
    check_res(16'd1, 1'b0, 16'd99, 103);

    check("ldab_exclusive", excl_viol, 32'd0);
    check("sel_when_idle", sel_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
